// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between the instruction-fetch and data-access requesters.
// Latency: grant is combinational in the request cycle; the response (data_ok) follows exactly one cycle later.
// Backpressure: an ungranted requester holds req/addr/data; data normally wins, and fetch is forced through after STARVE_LIMIT lockouts.
module sram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction fetch port (read only)
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data access port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // SRAM port
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  // performance counter
  output logic [31:0] perf_inst_stall
);

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        starve_hit;
  logic        inst_gnt;
  logic        data_gnt;
  logic        resp_valid;
  owner_e      resp_owner;

  // Grant selection: data has priority unless fetch has been locked out STARVE_LIMIT times in a row.
  // Everything is held off while reset is asserted.
  always_comb begin
    starve_hit = 1'b0;
    data_gnt   = 1'b0;
    inst_gnt   = 1'b0;
    if (resetn) begin
      starve_hit = inst_req && (starve_cnt == LIMIT);
      data_gnt   = data_req && !starve_hit;
      inst_gnt   = inst_req && !data_gnt;
    end
  end

  // addr_ok is simply the grant; acceptance is req & addr_ok on the requester side.
  assign inst_addr_ok = inst_gnt;
  assign data_addr_ok = data_gnt;

  // SRAM drive: route the granted address; only a data write enables byte lanes.
  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = 4'b0000;
    mem_addr  = inst_addr;
    mem_wdata = data_wdata;
    if (data_gnt) begin
      mem_en   = 1'b1;
      mem_addr = data_addr;
      mem_wen  = data_wr ? data_wstrb : 4'b0000;
    end else if (inst_gnt) begin
      mem_en   = 1'b1;
      mem_addr = inst_addr;
    end
  end

  // Response tracking: remember who owns the access issued this cycle so its data_ok fires next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid <= 1'b0;
      resp_owner <= OWN_INST;
    end else begin
      resp_valid <= inst_gnt || data_gnt;
      if (data_gnt) begin
        resp_owner <= OWN_DATA;
      end else if (inst_gnt) begin
        resp_owner <= OWN_INST;
      end
    end
  end

  // Response steering: read data comes straight from the SRAM; only the owner sees data_ok.
  assign inst_data_ok = resetn && resp_valid && (resp_owner == OWN_INST);
  assign data_data_ok = resetn && resp_valid && (resp_owner == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Starvation counter: counts data grants that lock out a pending fetch, capped at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= 4'd0;
    end else if (!inst_req || inst_gnt) begin
      starve_cnt <= 4'd0;
    end else if (data_gnt && (starve_cnt < LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Fetch stall counter: one count per cycle a fetch is waiting, saturating at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_inst_stall <= 32'd0;
    end else if (inst_req && !inst_gnt && (perf_inst_stall != 32'hFFFF_FFFF)) begin
      perf_inst_stall <= perf_inst_stall + 32'd1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus constrained-random traffic.
// Expectations come from a transaction-level model (grant rule, reference memory, pending response).
// Inputs change 1 time unit after the rising edge; outputs are sampled 5 units later.
module tb_sram_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] perf_inst_stall;

  always #5 clk = ~clk;

  sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .perf_inst_stall(perf_inst_stall)
  );

  // Behavioural single-port SRAM (one-cycle read latency, byte write enables).
  logic [31:0] sram [256];
  logic [31:0] ref_mem [256];
  logic        preload = 1'b0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) sram[i] <= ref_mem[i];
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= sram[mem_addr[9:2]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          pend_vld, pend_is_data, pend_wr;
  logic [31:0] pend_val;
  int          starve;
  logic [31:0] perf;
  bit          last_i_gnt, last_d_gnt;
  int          dut_i_acc, dut_i_dok;

  // One clock cycle: inputs already applied; check at mid-cycle, update model, advance.
  task automatic step();
    bit eg_i, eg_d;
    logic [31:0] w;
    #4;
    dut_i_acc += int'(inst_addr_ok);
    dut_i_dok += int'(inst_data_ok);
    if (!resetn) begin
      check("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
      check("rst_data_addr_ok", 32'(data_addr_ok), 0);
      check("rst_inst_data_ok", 32'(inst_data_ok), 0);
      check("rst_data_data_ok", 32'(data_data_ok), 0);
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_mem_wen", 32'(mem_wen), 0);
      check("rst_perf", perf_inst_stall, 0);
      pend_vld = 0; starve = 0; perf = 0;
      last_i_gnt = 0; last_d_gnt = 0;
    end else begin
      eg_d = data_req && !(inst_req && starve == LIMIT);
      eg_i = inst_req && !eg_d;
      check("inst_addr_ok", 32'(inst_addr_ok), 32'(eg_i));
      check("data_addr_ok", 32'(data_addr_ok), 32'(eg_d));
      check("mem_en", 32'(mem_en), 32'(eg_i || eg_d));
      check("mem_wen", 32'(mem_wen), (eg_d && data_wr) ? 32'(data_wstrb) : 32'd0);
      if (eg_i || eg_d) check("mem_addr", mem_addr, eg_d ? data_addr : inst_addr);
      if (eg_d && data_wr) check("mem_wdata", mem_wdata, data_wdata);
      check("inst_data_ok", 32'(inst_data_ok), 32'(pend_vld && !pend_is_data));
      check("data_data_ok", 32'(data_data_ok), 32'(pend_vld && pend_is_data));
      if (pend_vld && !pend_wr) begin
        if (pend_is_data) check("data_rdata", data_rdata, pend_val);
        else              check("inst_rdata", inst_rdata, pend_val);
      end
      check("perf_inst_stall", perf_inst_stall, perf);
      // model update for the coming edge
      pend_vld = eg_i || eg_d;
      pend_is_data = eg_d;
      pend_wr = eg_d && data_wr;
      if (eg_i) pend_val = ref_mem[inst_addr[9:2]];
      if (eg_d) begin
        pend_val = ref_mem[data_addr[9:2]];
        if (data_wr) begin
          w = ref_mem[data_addr[9:2]];
          for (int b = 0; b < 4; b++) if (data_wstrb[b]) w[8*b +: 8] = data_wdata[8*b +: 8];
          ref_mem[data_addr[9:2]] = w;
        end
      end
      if (!inst_req || eg_i) starve = 0;
      else if (eg_d && starve < LIMIT) starve++;
      if (inst_req && !eg_i && perf != 32'hFFFF_FFFF) perf++;
      last_i_gnt = eg_i; last_d_gnt = eg_d;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    inst_req = 0; data_req = 0; data_wr = 0; data_wstrb = '0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 0;
    step();
    resetn = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[32'h100 >> 2] = 32'h1122_3344;
    preload = 1;
    @(posedge clk); #1;
    step();                     // reset state, also loads the SRAM
    preload = 0;
    resetn = 1;

    // fetch only
    inst_req = 1; inst_addr = 32'h100; step();
    idle(); step();

    // contention: data wins, fetch follows
    inst_req = 1; inst_addr = 32'h0;
    data_req = 1; data_wr = 0; data_addr = 32'h200; step();
    data_req = 0; step();
    idle(); step();
    check("contention_perf", perf_inst_stall, 32'd1);

    // byte write then read back
    data_req = 1; data_wr = 1; data_wstrb = 4'b0010; data_addr = 32'h40; data_wdata = 32'hAABB_CCDD;
    step();
    data_wr = 0; data_wstrb = '0; step();
    idle(); step();

    // starvation guard
    do_reset();
    inst_req = 1; inst_addr = 32'h10;
    data_req = 1; data_wr = 0; data_addr = 32'h20;
    repeat (LIMIT) step();
    check("starve_perf", perf_inst_stall, 32'(LIMIT));
    check("starve_inst_forced", 32'(inst_addr_ok), 32'd1);
    step();
    inst_req = 0;
    check("starve_data_next", 32'(data_addr_ok), 32'd1);
    step();
    idle(); step();

    // reset while a data read is outstanding
    data_req = 1; data_wr = 0; data_addr = 32'h30; inst_req = 1; inst_addr = 32'h34;
    step();
    resetn = 0; step();
    resetn = 1; idle(); step();
    step();

    // throughput: eight back-to-back fetches
    dut_i_acc = 0; dut_i_dok = 0;
    for (int k = 0; k < 8; k++) begin
      inst_req = 1; inst_addr = 32'h300 + 32'(4 * k); step();
    end
    idle(); step();
    check("thru_acc", 32'(dut_i_acc), 32'd8);
    check("thru_dok", 32'(dut_i_dok), 32'd8);

    // constrained random traffic; ungranted requests are held stable
    for (int n = 0; n < 600; n++) begin
      if (!inst_req || last_i_gnt) begin
        inst_req = ($urandom_range(0, 3) != 0);
        inst_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!data_req || last_d_gnt) begin
        data_req = ($urandom_range(0, 2) != 0);
        data_wr = $urandom_range(0, 1) == 1;
        data_wstrb = data_wr ? 4'($urandom_range(0, 15)) : 4'b0000;
        data_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        data_wdata = $urandom;
      end
      step();
    end
    idle(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
